// File: rtl/cpu_mem_access.sv
// Memory-access stage: byte-lane steering for stores, lane extraction with
// sign/zero extension for loads, over a word-addressed waitrequest bus.
package codes;
    typedef logic [31:0] size_t;
    typedef logic [5:0]  opcode_t;
    localparam opcode_t OP_LB  = 6'h20;
    localparam opcode_t OP_LH  = 6'h21;
    localparam opcode_t OP_LW  = 6'h23;
    localparam opcode_t OP_LBU = 6'h24;
    localparam opcode_t OP_LHU = 6'h25;
    localparam opcode_t OP_SB  = 6'h28;
    localparam opcode_t OP_SH  = 6'h29;
    localparam opcode_t OP_SW  = 6'h2B;
endpackage

module cpu_mem_access
    import codes::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic        start_i,
    input  opcode_t     opcode_i,
    input  size_t       effective_address_i,
    input  size_t       store_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        misaligned_o,
    output size_t       load_data_o,
    output size_t       address_o,
    output logic        read_o,
    output logic        write_o,
    output logic [3:0]  byteenable_o,
    output size_t       writedata_o,
    input  size_t       readdata_i,
    input  logic        waitrequest_i
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_COMPLETE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_t;

    state_t    r_state, w_next;
    logic      r_is_load, r_signed, r_misaligned;
    acc_size_t r_size;
    logic [1:0] r_off;
    logic [3:0] r_be;
    size_t     r_addr, r_wdata, r_load_data;

    logic      w_valid_op, w_is_load, w_signed, w_misaligned, w_accept;
    acc_size_t w_size;
    logic [1:0] w_off;
    logic [3:0] w_be;
    size_t     w_wdata, w_shifted, w_extract;

    always_comb begin
        w_valid_op = 1'b1;
        w_is_load  = 1'b1;
        w_signed   = 1'b0;
        w_size     = SZ_W;
        case (opcode_i)
            OP_LB:   begin w_size = SZ_B; w_signed = 1'b1; end
            OP_LBU:  w_size = SZ_B;
            OP_LH:   begin w_size = SZ_H; w_signed = 1'b1; end
            OP_LHU:  w_size = SZ_H;
            OP_LW:   w_size = SZ_W;
            OP_SB:   begin w_size = SZ_B; w_is_load = 1'b0; end
            OP_SH:   begin w_size = SZ_H; w_is_load = 1'b0; end
            OP_SW:   begin w_size = SZ_W; w_is_load = 1'b0; end
            default: w_valid_op = 1'b0;
        endcase
    end

    assign w_off        = effective_address_i[1:0];
    assign w_misaligned = ((w_size == SZ_H) && w_off[0]) || ((w_size == SZ_W) && (w_off != 2'd0));
    assign w_accept     = (r_state == S_IDLE) && start_i && w_valid_op;

    // Loads and stores share the same lane enables; data is replicated so
    // the enabled lanes always carry the low bits of rt.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data_i;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{store_data_i[7:0]}};
            end
            SZ_H: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = readdata_i >> {r_off, 3'b000};
    always_comb begin
        w_extract = w_shifted;
        case (r_size)
            SZ_B: w_extract = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
            SZ_H: w_extract = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next = w_misaligned ? S_COMPLETE : S_ACCESS;
            S_ACCESS:   if (!waitrequest_i) w_next = S_COMPLETE;
            S_COMPLETE: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (r_state != S_IDLE);
        done_o       = (r_state == S_COMPLETE);
        misaligned_o = (r_state == S_COMPLETE) && r_misaligned;
        read_o       = (r_state == S_ACCESS) && r_is_load;
        write_o      = (r_state == S_ACCESS) && !r_is_load;
        byteenable_o = (r_state == S_ACCESS) ? r_be : 4'b0000;
    end

    // Faulted requests leave the bus-facing registers untouched.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_is_load    <= 1'b0;
            r_signed     <= 1'b0;
            r_misaligned <= 1'b0;
            r_size       <= SZ_W;
            r_off        <= 2'd0;
            r_be         <= 4'b0000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_load_data  <= '0;
        end else begin
            if (w_accept) begin
                r_is_load    <= w_is_load;
                r_signed     <= w_signed;
                r_size       <= w_size;
                r_off        <= w_off;
                r_misaligned <= w_misaligned;
                if (!w_misaligned) begin
                    r_be    <= w_be;
                    r_addr  <= {effective_address_i[31:2], 2'b00};
                    r_wdata <= w_wdata;
                end
            end
            if ((r_state == S_ACCESS) && !waitrequest_i && r_is_load)
                r_load_data <= w_extract;
        end
    end

    assign address_o   = r_addr;
    assign writedata_o = r_wdata;
    assign load_data_o = r_load_data;
endmodule

// File: tb/tb_cpu_mem_access.sv
// Bench for cpu_mem_access: table of accesses with a bus responder and a
// scoreboard of expected completions, plus reset-abort and ignored-start cases.
module tb_cpu_mem_access;
    import codes::*;

    logic        clk = 1'b0;
    logic        reset_i, start_i, waitrequest_i;
    opcode_t     opcode_i;
    logic [31:0] effective_address_i, store_data_i, readdata_i;
    logic        busy_o, done_o, misaligned_o, read_o, write_o;
    logic [31:0] load_data_o, address_o, writedata_o;
    logic [3:0]  byteenable_o;

    cpu_mem_access dut (
        .clk(clk), .reset_i(reset_i), .start_i(start_i), .opcode_i(opcode_i),
        .effective_address_i(effective_address_i), .store_data_i(store_data_i),
        .busy_o(busy_o), .done_o(done_o), .misaligned_o(misaligned_o),
        .load_data_o(load_data_o), .address_o(address_o), .read_o(read_o),
        .write_o(write_o), .byteenable_o(byteenable_o), .writedata_o(writedata_o),
        .readdata_i(readdata_i), .waitrequest_i(waitrequest_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        opcode_t     op;
        logic [31:0] addr, sdata, rdata;
        int          nwait;
        bit          poke, mis, is_load;
        logic [3:0]  be;
        logic [31:0] wd, ld;
    } vec_t;

    typedef struct {
        bit          mis;
        logic [31:0] ld;
    } exp_t;

    vec_t vq[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input opcode_t op, input logic [31:0] addr, sdata, rdata, input int nwait,
                       input bit poke, mis, is_load, input logic [3:0] be, input logic [31:0] wd, ld);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.nwait = nwait;
        v.poke = poke; v.mis = mis; v.is_load = is_load; v.be = be; v.wd = wd; v.ld = ld;
        vq.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   cyc, strobes, done_cyc;
        bit   bus_ok, kind_ok;
        exp_t e;
        @(negedge clk);
        start_i = 1'b1; opcode_i = v.op; effective_address_i = v.addr; store_data_i = v.sdata;
        e.mis = v.mis; e.ld = v.ld;
        sb_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1; strobes = 0; done_cyc = -1; bus_ok = 1'b1; kind_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            start_i = 1'b0;
            waitrequest_i = 1'b0;
            if (read_o || write_o) begin
                strobes++;
                if (address_o !== (v.addr & ~32'h3) || byteenable_o !== v.be) bus_ok = 1'b0;
                if (!v.is_load && writedata_o !== v.wd) bus_ok = 1'b0;
                if (read_o !== v.is_load || write_o !== !v.is_load) kind_ok = 1'b0;
                if (v.poke && strobes == 1) begin
                    start_i = 1'b1;
                    opcode_i = v.is_load ? OP_SW : OP_LB;
                    effective_address_i = 32'h5555_5555;
                    store_data_i = 32'hFFFF_FFFF;
                end
                waitrequest_i = (strobes <= v.nwait);
                readdata_i = (strobes <= v.nwait) ? ~v.rdata : v.rdata;
            end
            if (done_o) begin
                done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL %s unexpected_done: got done expected none", tag);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, " misaligned"}, {31'd0, misaligned_o}, {31'd0, e.mis});
                    check({tag, " load_data"}, load_data_o, e.ld);
                end
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_latency"}, done_cyc, v.mis ? 1 : v.nwait + 2);
        check({tag, " strobe_cycles"}, strobes, v.mis ? 0 : v.nwait + 1);
        if (!v.mis) begin
            check({tag, " bus_fields"}, {31'd0, bus_ok}, 32'd1);
            check({tag, " strobe_kind"}, {31'd0, kind_ok}, 32'd1);
        end
        @(negedge clk);
        check({tag, " done_pulse_width"}, {30'd0, done_o, busy_o}, 32'd0);
    endtask

    initial begin
        bit saw_done;
        reset_i = 1'b1; start_i = 1'b0; opcode_i = '0; effective_address_i = '0;
        store_data_i = '0; readdata_i = '0; waitrequest_i = 1'b0;

        //  op      addr          sdata         rdata         nw poke mis load be       wd            ld
        add(OP_LW,  32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 1, 4'b1111, 32'h0,        32'hDEAD_BEEF);
        add(OP_LB,  32'h0000_1003, 32'h0,        32'h80FF_7F01, 3, 0, 0, 1, 4'b1000, 32'h0,        32'hFFFF_FF80);
        add(OP_LBU, 32'h0000_1003, 32'h0,        32'h80FF_7F01, 3, 0, 0, 1, 4'b1000, 32'h0,        32'h0000_0080);
        add(OP_SH,  32'h0000_2002, 32'h1234_5678, 32'h0,        0, 0, 0, 0, 4'b1100, 32'h5678_5678, 32'h0000_0080);
        add(OP_LW,  32'h0000_1002, 32'h0,        32'h0,        0, 0, 1, 1, 4'b0000, 32'h0,        32'h0000_0080);
        add(OP_LH,  32'h0000_1001, 32'h0,        32'h0,        0, 0, 1, 1, 4'b0000, 32'h0,        32'h0000_0080);
        add(OP_LH,  32'h0000_1002, 32'h0,        32'h8001_1234, 1, 0, 0, 1, 4'b1100, 32'h0,        32'hFFFF_8001);
        add(OP_LHU, 32'h0000_1000, 32'h0,        32'h8001_9234, 0, 0, 0, 1, 4'b0011, 32'h0,        32'h0000_9234);
        add(OP_SW,  32'h0000_4000, 32'hCAFE_F00D, 32'h0,        2, 1, 0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_9234);
        add(OP_SB,  32'h0000_3002, 32'h1234_56C3, 32'h0,        0, 0, 0, 0, 4'b0100, 32'hC3C3_C3C3, 32'h0000_9234);
        add(OP_LB,  32'h0000_2001, 32'h0,        32'h0000_7F00, 0, 0, 0, 1, 4'b0010, 32'h0,        32'h0000_007F);
        add(OP_SH,  32'h0000_2001, 32'hFFFF_BEEF, 32'h0,        0, 0, 1, 0, 4'b0000, 32'h0,        32'h0000_007F);
        add(OP_SH,  32'h0000_2000, 32'hFFFF_BEEF, 32'h0,        0, 0, 0, 0, 4'b0011, 32'hBEEF_BEEF, 32'h0000_007F);
        add(OP_SB,  32'h0000_3001, 32'h0000_00AB, 32'h0,        0, 0, 0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0000_0000);

        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        check("reset ctrl", {27'd0, busy_o, done_o, misaligned_o, read_o, write_o}, 32'd0);
        check("reset byteenable", {28'd0, byteenable_o}, 32'd0);
        check("reset load_data", load_data_o, 32'd0);
        check("reset address", address_o, 32'd0);
        check("reset writedata", writedata_o, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(vq[i], $sformatf("vec%0d", i));

        // An unlisted opcode in IDLE must not start anything.
        @(negedge clk);
        start_i = 1'b1; opcode_i = 6'h3F; effective_address_i = 32'h1000;
        @(negedge clk);
        start_i = 1'b0;
        check("bad_opcode busy", {30'd0, busy_o, read_o | write_o}, 32'd0);
        @(negedge clk);
        check("bad_opcode done", {31'd0, done_o}, 32'd0);

        // Reset in the second wait cycle of an SW aborts without done.
        @(negedge clk);
        start_i = 1'b1; opcode_i = OP_SW; effective_address_i = 32'h3000;
        store_data_i = 32'h1122_3344; waitrequest_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("abort write_strobe", {31'd0, write_o}, 32'd1);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0; waitrequest_i = 1'b0;
        check("abort write_o", {31'd0, write_o}, 32'd0);
        check("abort busy", {31'd0, busy_o}, 32'd0);
        check("abort load_data", load_data_o, 32'd0);
        saw_done = done_o;
        repeat (3) begin
            @(negedge clk);
            saw_done |= done_o;
        end
        check("abort no_done", {31'd0, saw_done}, 32'd0);

        run_vec(vq[13], "post_reset_sb");
        check("scoreboard drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
